// File: rtl/bias_acc_pkg.sv
// Shared types, default widths and saturation/ReLU helpers for the layer-9 bias accumulator.
// The lane word format is fixed by W_DEF; the helpers operate on that format.
package bias_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam int W_DEF      = 18;
    localparam int PASS_W_DEF = 6;
    localparam int ACC_W_DEF  = W_DEF + PASS_W_DEF;

    localparam logic signed [ACC_W_DEF-1:0] SAT_MAX = ACC_W_DEF'((1 << (W_DEF - 1)) - 1);
    localparam logic signed [ACC_W_DEF-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [W_DEF-1:0]     W_MAX   = {1'b0, {(W_DEF-1){1'b1}}};
    localparam logic signed [W_DEF-1:0]     W_MIN   = {1'b1, {(W_DEF-1){1'b0}}};

    function automatic logic signed [W_DEF-1:0] sat_w(input logic signed [ACC_W_DEF-1:0] acc);
        if (acc > SAT_MAX)
            return W_MAX;
        else if (acc < SAT_MIN)
            return W_MIN;
        else
            return acc[W_DEF-1:0];
    endfunction

    function automatic logic signed [W_DEF-1:0] relu_w(input logic signed [W_DEF-1:0] x);
        return x[W_DEF-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/bias_acc_relu_layer9_lane.sv
// One lane: accumulator register, bias fold-in on the first beat, saturation and optional ReLU.
// Optional feature macro: BIAS_ACC_RELU_EN (ReLU applied after saturation when defined).
module bias_acc_lane
    import bias_acc_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_first,
    input  logic         i_accept,
    input  logic [W-1:0] i_bias,
    input  logic [W-1:0] i_in,
    output logic [W-1:0] o_res
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [W-1:0]     w_sat;

    // The first beat of a group starts from the bias instead of the stale accumulator.
    assign w_base     = i_first ? ACC_W'(signed'(i_bias)) : r_acc;
    assign w_acc_next = w_base + ACC_W'(signed'(i_in));

    always_ff @(posedge clk) begin
        if (rst)
            r_acc <= '0;
        else if (i_accept)
            r_acc <= w_acc_next;
    end

    assign w_sat = sat_w(w_acc_next);

`ifdef BIAS_ACC_RELU_EN
    assign o_res = relu_w(w_sat);
`else
    assign o_res = w_sat;
`endif

endmodule

// File: rtl/bias_acc_relu_layer9.sv
// Layer-9 bias accumulator: sums n_pass partial-sum beats plus bias per lane, then saturates.
// Optional feature macro: BIAS_ACC_RELU_EN (negative lane results forced to 0 when defined).
module bias_acc_relu_layer9
    import bias_acc_pkg::*;
#(
    parameter int N_adder_tree = 16,
    parameter int W            = W_DEF,
    parameter int PASS_W       = PASS_W_DEF,
    parameter int ACC_W        = W + PASS_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_adder_tree*W-1:0] bias,
    input  logic [PASS_W-1:0]         n_pass,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_adder_tree*W-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_adder_tree*W-1:0] out_data,
    output logic                      busy
);

    state_t                    r_state;
    logic [PASS_W-1:0]         r_pass_cnt;
    logic [PASS_W-1:0]         r_n_eff;
    logic                      r_out_valid;
    logic [N_adder_tree*W-1:0] r_out_data;

    logic                      w_accept;
    logic                      w_first;
    logic [PASS_W-1:0]         w_n_eff_first;
    logic [PASS_W-1:0]         w_cnt_inc;
    logic                      w_last;
    logic [N_adder_tree*W-1:0] w_res;

    assign in_ready      = !rst && (r_state != ST_OUT);
    assign w_accept      = in_valid && in_ready;
    assign w_first       = (r_state == ST_IDLE);
    assign w_n_eff_first = (n_pass == '0) ? PASS_W'(1) : n_pass;
    assign w_cnt_inc     = r_pass_cnt + PASS_W'(1);
    assign w_last        = w_first ? (w_n_eff_first == PASS_W'(1)) : (w_cnt_inc == r_n_eff);

    for (genvar k = 0; k < N_adder_tree; k++) begin : g_lane
        bias_acc_lane #(
            .W     (W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_first  (w_first),
            .i_accept (w_accept),
            .i_bias   (bias[W*k +: W]),
            .i_in     (in_data[W*k +: W]),
            .o_res    (w_res[W*k +: W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pass_cnt  <= '0;
            r_n_eff     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pass_cnt <= PASS_W'(1);
                        r_n_eff    <= w_n_eff_first;
                        if (w_last) begin
                            r_state     <= ST_OUT;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_res;
                        end else begin
                            r_state <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (w_accept) begin
                        r_pass_cnt <= w_cnt_inc;
                        if (w_last) begin
                            r_state     <= ST_OUT;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_res;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bias_acc_relu_layer9.sv
// Scoreboard bench for bias_acc_relu_layer9: directed groups push expected results, a monitor
// pops and compares on each output handshake. Expectations follow BIAS_ACC_RELU_EN when defined.
module tb_bias_acc_relu_layer9;

    localparam int N      = 16;
    localparam int W      = 18;
    localparam int PASS_W = 6;

    typedef logic [N*W-1:0] vec_t;

    logic              clk = 1'b0;
    logic              rst;
    vec_t              bias;
    logic [PASS_W-1:0] n_pass;
    logic              in_valid;
    logic              in_ready;
    vec_t              in_data;
    logic              out_valid;
    logic              out_ready;
    vec_t              out_data;
    logic              busy;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];

    bias_acc_relu_layer9 dut (
        .clk       (clk),
        .rst       (rst),
        .bias      (bias),
        .n_pass    (n_pass),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int l0, input int l1);
        vec_t v;
        v = '0;
        v[0 +: W] = l0[W-1:0];
        v[W +: W] = l1[W-1:0];
        return v;
    endfunction

    function automatic int rl(input int x);
`ifdef BIAS_ACC_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    function automatic vec_t ex(input int l0, input int l1);
        return mk(rl(l0), rl(l1));
    endfunction

    task automatic chk(input string nm, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Holds a beat until accepted; tries = number of edges it took.
    task automatic send_beat(input vec_t d, output int tries);
        bit ok;
        ok       = 1'b0;
        tries    = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!ok && tries < 64) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        if (!ok) chk("beat_timeout", vec_t'(0), vec_t'(1));
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", out_data, vec_t'(0));
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("out_data", out_data, e);
            end
        end
    end

    initial begin
        int   t;
        vec_t e;
        vec_t b;
        vec_t d;

        rst = 1'b1; bias = '0; n_pass = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", vec_t'(out_valid), vec_t'(0));
        chk("rst_out_data",  out_data,          vec_t'(0));
        chk("rst_busy",      vec_t'(busy),      vec_t'(0));
        chk("rst_in_ready",  vec_t'(in_ready),  vec_t'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", vec_t'(in_ready), vec_t'(1));

        // Single pass with output hold; lane 15 saturates on 131071 + 1.
        out_ready = 1'b0;
        n_pass = 6'd1;
        b = mk(5048, -20); b[15*W +: W] = 18'h1FFFF;
        d = mk(100, 7);    d[15*W +: W] = 18'h00001;
        e = ex(5148, -13); e[15*W +: W] = 18'h1FFFF;
        bias = b;
        sb.push_back(e);
        send_beat(d, t);
        chk("single_latency_valid", vec_t'(out_valid), vec_t'(1));
        chk("single_in_ready_out",  vec_t'(in_ready),  vec_t'(0));
        repeat (3) begin
            @(negedge clk);
            chk("single_hold", out_data, e);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("single_done_valid", vec_t'(out_valid), vec_t'(0));

        // Multi-pass: -500 + 1000 + 2000 - 300 = 2200; lane1 10 - 4 - 4 - 9 = -7.
        out_ready = 1'b0;
        n_pass = 6'd3;
        bias = mk(-500, 10);
        sb.push_back(ex(2200, -7));
        send_beat(mk(1000, -4), t);
        n_pass = 6'd1;
        bias = mk(9999, 9999);
        send_beat(mk(2000, -4), t);
        chk("multi_not_early", vec_t'(out_valid), vec_t'(0));
        send_beat(mk(-300, -9), t);
        chk("multi_latency_valid", vec_t'(out_valid), vec_t'(1));
        repeat (2) begin
            @(negedge clk);
            chk("multi_in_ready_out", vec_t'(in_ready), vec_t'(0));
            chk("multi_busy_out",     vec_t'(busy),     vec_t'(1));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("next_grp_in_ready", vec_t'(in_ready), vec_t'(1));

        // Saturation both directions, issued the cycle after the handshake.
        n_pass = 6'd2;
        bias = mk(131071, -131072);
        sb.push_back(ex(131071, -131072));
        send_beat(mk(131071, -131072), t);
        chk("next_grp_first_edge", vec_t'(t), vec_t'(1));
        send_beat(mk(131071, -131072), t);

        // Per-lane ReLU: -10 + 5 = -5, 3 + 4 = 7.
        n_pass = 6'd1;
        bias = mk(-10, 3);
        sb.push_back(ex(-5, 7));
        send_beat(mk(5, 4), t);

        // Backpressure with n_pass = 0; a pending beat must wait out the OUT state.
        n_pass = 6'd0;
        bias = mk(1, -1);
        e = ex(3, -6);
        sb.push_back(e);
        send_beat(mk(2, -5), t);
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("npass0_valid", vec_t'(out_valid), vec_t'(1));
        n_pass = 6'd1;
        bias = mk(0, 0);
        in_data = mk(50, 60);
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid",    vec_t'(out_valid), vec_t'(1));
            chk("bp_data",     out_data,          e);
            chk("bp_in_ready", vec_t'(in_ready),  vec_t'(0));
        end
        sb.push_back(ex(50, 60));
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_beat(mk(50, 60), t);

        // Reset during beat 2 of 4: nothing emitted, next group starts clean.
        for (int i = 0; i < 20 && out_valid; i++) @(posedge clk);
        #1;
        n_pass = 6'd4;
        bias = mk(1000, 1000);
        send_beat(mk(1, 1), t);
        in_data = mk(2, 2);
        in_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", vec_t'(in_ready), vec_t'(0));
        @(posedge clk); #1;
        chk("midrst_busy",  vec_t'(busy),      vec_t'(0));
        chk("midrst_valid", vec_t'(out_valid), vec_t'(0));
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", vec_t'(in_ready), vec_t'(1));
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_out", vec_t'(out_valid), vec_t'(0));
        end
        @(posedge clk); #1;
        n_pass = 6'd2;
        bias = mk(7, -7);
        sb.push_back(ex(14, -14));
        send_beat(mk(3, 3), t);
        send_beat(mk(4, -10), t);

        for (int i = 0; i < 50 && (sb.size() != 0 || out_valid); i++) @(posedge clk);
        #1;
        chk("sb_drained", vec_t'(sb.size()), vec_t'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
